// File: rtl/axis_s2mm_packetizer.sv
// axis_s2mm_packetizer
// Forwards DDR read-FIFO beats to the DMA S2MM stream through an output register
// plus a one-entry skid register. TLAST is generated on the final beat of a
// software-programmed length. Upstream TLAST is not used. Upstream is only
// accepted while a packet is armed.
// Optional build macro: AXIS_S2MM_PACKETIZER_STATS_EN adds the pkt_count and
// stall_count outputs.
module axis_s2mm_packetizer #(
  parameter int DATA_W = 512,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                cfg_start,
  output logic                cfg_busy,
  output logic                pkt_done,
  output logic [LEN_W-1:0]    beat_cnt,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready
`ifdef AXIS_S2MM_PACKETIZER_STATS_EN
  ,
  output logic [31:0]         pkt_count,
  output logic [31:0]         stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_remaining;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic               r_busy;

  logic               r_out_valid;
  logic               r_out_last;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_skid_valid;
  logic               r_skid_last;
  logic [DATA_W-1:0]  r_skid_data;

  logic               w_s_ready;
  logic               w_s_hs;
  logic               w_m_hs;
  logic               w_out_load;
  logic               w_in_last;

  // Upstream is only accepted while running and the skid slot is free, so the
  // skid can never be asked to hold a second beat.
  assign w_s_ready  = (r_state == ST_RUN) && !r_skid_valid;
  assign w_s_hs     = s_axis_tvalid && w_s_ready;
  assign w_m_hs     = r_out_valid && m_axis_tready;
  assign w_out_load = !r_out_valid || m_axis_tready;
  assign w_in_last  = (r_remaining == LEN_W'(1));

  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tlast  = r_out_last;
  assign m_axis_tkeep  = '1;
  assign cfg_busy      = r_busy;
  assign beat_cnt      = r_beat_cnt;
  // Must coincide with the TLAST handshake itself, so it is decoded from the
  // registered output stage and the downstream ready.
  assign pkt_done      = w_m_hs && r_out_last;

  // Packet control: arm on cfg_start, count accepted beats, wait for TLAST to leave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_beat_cnt  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            // A zero length is treated as a single-beat packet.
            r_remaining <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
            r_beat_cnt  <= '0;
            r_busy      <= 1'b1;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_s_hs) begin
            r_remaining <= r_remaining - LEN_W'(1);
            r_beat_cnt  <= r_beat_cnt + LEN_W'(1);
            if (w_in_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_m_hs && r_out_last) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register with one-entry skid: the skid drains first to keep beat order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_last  <= 1'b0;
      r_skid_data  <= '0;
    end else begin
      if (w_out_load) begin
        if (r_skid_valid) begin
          // No new beat can arrive here: ready is low while the skid is full.
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_out_last   <= r_skid_last;
          r_skid_valid <= 1'b0;
        end else begin
          r_out_valid <= w_s_hs;
          if (w_s_hs) begin
            r_out_data <= s_axis_tdata;
            r_out_last <= w_in_last;
          end
        end
      end else if (w_s_hs) begin
        // Output is full and stalled: park the accepted beat.
        r_skid_valid <= 1'b1;
        r_skid_data  <= s_axis_tdata;
        r_skid_last  <= w_in_last;
      end
    end
  end

`ifdef AXIS_S2MM_PACKETIZER_STATS_EN
  logic [31:0] r_pkt_count;
  logic [31:0] r_stall_count;

  // Completed-packet counter (wrapping) and downstream stall counter (saturating).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (pkt_done) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
      if (r_out_valid && !m_axis_tready && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign pkt_count   = r_pkt_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_axis_s2mm_packetizer.sv
// Self-checking bench for axis_s2mm_packetizer: accepted upstream beats are
// pushed with their expected TLAST into a scoreboard and popped on M handshakes.
module tb_axis_s2mm_packetizer;
  localparam int DATA_W = 512;
  localparam int LEN_W  = 16;

  typedef logic [DATA_W:0] w_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [LEN_W-1:0]    cfg_len = '0;
  logic                cfg_start = 1'b0;
  logic                cfg_busy;
  logic                pkt_done;
  logic [LEN_W-1:0]    beat_cnt;
  logic [DATA_W-1:0]   s_axis_tdata = '0;
  logic                s_axis_tvalid = 1'b0;
  logic                s_axis_tready;
  logic [DATA_W-1:0]   m_axis_tdata;
  logic [DATA_W/8-1:0] m_axis_tkeep;
  logic                m_axis_tvalid;
  logic                m_axis_tlast;
  logic                m_axis_tready = 1'b0;
`ifdef AXIS_S2MM_PACKETIZER_STATS_EN
  logic [31:0]         pkt_count;
  logic [31:0]         stall_count;
`endif

  axis_s2mm_packetizer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_len       (cfg_len),
    .cfg_start     (cfg_start),
    .cfg_busy      (cfg_busy),
    .pkt_done      (pkt_done),
    .beat_cnt      (beat_cnt),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
`ifdef AXIS_S2MM_PACKETIZER_STATS_EN
    ,
    .pkt_count     (pkt_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model / scoreboard state
  w_t               sb[$];
  logic             m_busy = 1'b0;
  int               m_rem = 0;
  logic [LEN_W-1:0] m_cnt = '0;
  int               seq = 0;
  int               cyc = 0;
  int               rdy_mode = 0;
  logic             src_en = 1'b1;
  int               n_beats = 0;
  int               n_pd = 0;
  int               first_hs = -1;
  int               last_hs = -1;
  int               stall_seen = 0;
  logic             prev_stall = 1'b0;
  w_t               prev_out = '0;

  task automatic chk(input string tag, input w_t got, input w_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int s);
    return {16{32'(s) ^ 32'h5A00_0000}};
  endfunction

  task automatic drive();
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (cyc % 3 == 0);
      default: m_axis_tready = 1'b0;
    endcase
    s_axis_tvalid = src_en;
    s_axis_tdata  = mk(seq);
  endtask

  // One clock cycle: observe at negedge, update model, re-drive after posedge.
  task automatic step();
    logic s_hs;
    logic m_hs;
    logic pd_exp;
    logic start_acc;
    w_t   e;
    @(negedge clk);
    if (!m_busy || m_rem == 0) chk("s_ready_gate", w_t'(s_axis_tready), w_t'(0));
    chk("cfg_busy", w_t'(cfg_busy), w_t'(m_busy));
    chk("beat_cnt", w_t'(beat_cnt), w_t'(m_cnt));
    if (prev_stall) begin
      chk("hold_valid", w_t'(m_axis_tvalid), w_t'(1));
      chk("hold_data", {m_axis_tlast, m_axis_tdata}, prev_out);
    end
    s_hs   = s_axis_tvalid && s_axis_tready;
    m_hs   = m_axis_tvalid && m_axis_tready;
    pd_exp = 1'b0;
    if (m_hs) begin
      chk("sb_empty_on_beat", w_t'(sb.size() == 0), w_t'(0));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("m_beat", {m_axis_tlast, m_axis_tdata}, e);
        pd_exp = e[DATA_W];
        n_beats++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
    end
    chk("pkt_done", w_t'(pkt_done), w_t'(pd_exp));
    if (pkt_done) n_pd++;
    if (m_axis_tvalid && !m_axis_tready) stall_seen++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_out   = {m_axis_tlast, m_axis_tdata};
    start_acc  = cfg_start && !m_busy;
    if (s_hs) begin
      sb.push_back({(m_rem == 1), s_axis_tdata});
      m_rem--;
      m_cnt++;
    end
    if (pd_exp) m_busy = 1'b0;
    if (start_acc) begin
      m_busy = 1'b1;
      m_rem  = (cfg_len == '0) ? 1 : int'(cfg_len);
      m_cnt  = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_hs) seq++;
    cfg_start = 1'b0;
    drive();
  endtask

  task automatic wait_idle(input string tag);
    int b;
    b = 0;
    while (m_busy && b < 300) begin
      step();
      b++;
    end
    chk({tag, "_timeout"}, w_t'(m_busy), w_t'(0));
  endtask

  task automatic start_pkt(input int len, input int mode);
    rdy_mode  = mode;
    n_beats   = 0;
    n_pd      = 0;
    first_hs  = -1;
    cfg_len   = LEN_W'(len);
    cfg_start = 1'b1;
    drive();
    step();
    chk("busy_after_start", w_t'(cfg_busy), w_t'(1));
    chk("s_ready_after_start", w_t'(s_axis_tready), w_t'(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_m_valid", w_t'(m_axis_tvalid), w_t'(0));
    chk("rst_m_last", w_t'(m_axis_tlast), w_t'(0));
    chk("rst_m_data", w_t'(m_axis_tdata), w_t'(0));
    chk("rst_busy", w_t'(cfg_busy), w_t'(0));
    chk("rst_beat_cnt", w_t'(beat_cnt), w_t'(0));
    chk("rst_s_ready", w_t'(s_axis_tready), w_t'(0));
    chk("rst_pkt_done", w_t'(pkt_done), w_t'(0));
    sb.delete();
    m_busy     = 1'b0;
    m_rem      = 0;
    m_cnt      = '0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
  endtask

  initial begin
    int b;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_s_ready", w_t'(s_axis_tready), w_t'(0));
    chk("reset_m_valid", w_t'(m_axis_tvalid), w_t'(0));
    chk("reset_m_last", w_t'(m_axis_tlast), w_t'(0));
    chk("reset_m_data", w_t'(m_axis_tdata), w_t'(0));
    chk("reset_busy", w_t'(cfg_busy), w_t'(0));
    chk("reset_pkt_done", w_t'(pkt_done), w_t'(0));
    chk("reset_beat_cnt", w_t'(beat_cnt), w_t'(0));
    chk("tkeep", w_t'(m_axis_tkeep), w_t'({(DATA_W/8){1'b1}}));
    rst = 1'b0;
    drive();
    step();

    // basic 4-beat packet at full rate
    start_pkt(4, 0);
    wait_idle("basic");
    chk("basic_beats", w_t'(n_beats), w_t'(4));
    chk("basic_pd", w_t'(n_pd), w_t'(1));
    chk("basic_consecutive", w_t'(last_hs - first_hs), w_t'(3));
    chk("basic_beat_cnt", w_t'(beat_cnt), w_t'(4));
    chk("basic_s_ready_after", w_t'(s_axis_tready), w_t'(0));
    $display("basic: beats=%0d pkt_done=%0d", n_beats, n_pd);
    step();

    // backpressure 1,0,0 pattern exercises the skid register
    start_pkt(8, 1);
    wait_idle("bp");
    chk("bp_beats", w_t'(n_beats), w_t'(8));
    chk("bp_pd", w_t'(n_pd), w_t'(1));
    $display("backpressure: beats=%0d pkt_done=%0d", n_beats, n_pd);
    step();

    // zero length and one length
    start_pkt(0, 0);
    wait_idle("len0");
    chk("len0_beats", w_t'(n_beats), w_t'(1));
    chk("len0_pd", w_t'(n_pd), w_t'(1));
    $display("len0: beats=%0d pkt_done=%0d", n_beats, n_pd);
    start_pkt(1, 0);
    wait_idle("len1");
    chk("len1_beats", w_t'(n_beats), w_t'(1));
    chk("len1_pd", w_t'(n_pd), w_t'(1));
    $display("len1: beats=%0d pkt_done=%0d", n_beats, n_pd);

    // busy guard: second start one cycle later is ignored
    start_pkt(2, 0);
    cfg_len   = LEN_W'(5);
    cfg_start = 1'b1;
    step();
    wait_idle("guard");
    repeat (4) step();
    chk("guard_beats", w_t'(n_beats), w_t'(2));
    chk("guard_pd", w_t'(n_pd), w_t'(1));
    chk("guard_beat_cnt", w_t'(beat_cnt), w_t'(2));
    chk("guard_busy", w_t'(cfg_busy), w_t'(0));
    $display("busy_guard: beats=%0d pkt_done=%0d", n_beats, n_pd);

    // reset in the middle of a 16-beat packet with output stalled
    start_pkt(16, 0);
    b = 0;
    while (m_cnt < 6 && b < 50) begin
      step();
      b++;
    end
    chk("midrst_reach6", w_t'(m_cnt >= 6), w_t'(1));
    rdy_mode = 2;
    drive();
    step();
    step();
    do_reset();
    $display("reset_mid_packet: beat_cnt=%0d busy=%0d", beat_cnt, cfg_busy);
    step();
    start_pkt(2, 0);
    wait_idle("post_rst");
    chk("post_rst_beats", w_t'(n_beats), w_t'(2));
    chk("post_rst_pd", w_t'(n_pd), w_t'(1));
    $display("post_reset: beats=%0d pkt_done=%0d", n_beats, n_pd);

    // packets 3,1,2 with exactly 5 stall cycles, from a fresh reset
    do_reset();
    step();
    start_pkt(3, 0);
    wait_idle("st3");
    start_pkt(1, 2);
    stall_seen = 0;
    b = 0;
    while (stall_seen < 5 && b < 50) begin
      step();
      b++;
    end
    chk("stall_reach5", w_t'(stall_seen), w_t'(5));
    rdy_mode = 0;
    drive();
    wait_idle("st1");
    start_pkt(2, 0);
    wait_idle("st2");
`ifdef AXIS_S2MM_PACKETIZER_STATS_EN
    chk("pkt_count", w_t'(pkt_count), w_t'(3));
    chk("stall_count", w_t'(stall_count), w_t'(5));
    $display("stats: pkt_count=%0d stall_count=%0d", pkt_count, stall_count);
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
